// File: rtl/mc_ctrl_if.sv
// Control bundle between the multicycle main controller and the RV32I datapath.
// master = controller side, slave = datapath/instruction-register side.
interface mc_ctrl_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       alu_zero;
   logic       alu_res0;
   logic       mem_ready;
   logic       mem_req;
   logic       mem_we;
   logic       adr_src;
   logic       ir_write;
   logic       pc_write;
   logic       pc_src;
   logic       reg_write;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [3:0] alu_ctrl;
   logic [2:0] imm_sel;
   logic       illegal;

   modport master (
      input  op, funct3, funct7b5, alu_zero, alu_res0, mem_ready,
      output mem_req, mem_we, adr_src, ir_write, pc_write, pc_src, reg_write,
             result_src, alu_src_a, alu_src_b, alu_ctrl, imm_sel, illegal
   );

   modport slave (
      output op, funct3, funct7b5, alu_zero, alu_res0, mem_ready,
      input  mem_req, mem_we, adr_src, ir_write, pc_write, pc_src, reg_write,
             result_src, alu_src_a, alu_src_b, alu_ctrl, imm_sel, illegal
   );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle RV32I main controller: Moore FSM sequencing fetch, decode, execute,
// memory and writeback; outputs decoded from state and forced low during reset.
module mc_ctrl (
   input  logic      clk,
   input  logic      rst_n,
   mc_ctrl_if.master bus
);
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_FENCE = 7'b0001111;

   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                          ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                          ALU_OR = 4'd8, ALU_AND = 4'd9;
   localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011,
                          IMM_U = 3'b100;
   localparam logic [1:0] A_PC = 2'b00, A_OLDPC = 2'b01, A_RS1 = 2'b10, A_ZERO = 2'b11;
   localparam logic [1:0] B_RS2 = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10;
   localparam logic [1:0] RES_ALUOUT = 2'b00, RES_RDATA = 2'b01, RES_ALU = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
      S_LUI, S_AUIPC, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRLINK, S_TRAP
   } state_t;

   state_t     state, state_nx;
   logic       mem_req, mem_we, adr_src, ir_write, pc_write, pc_src, reg_write, illegal;
   logic [1:0] result_src, alu_src_a, alu_src_b;
   logic [3:0] alu_ctrl;
   logic [2:0] imm_sel;
   logic       br_taken;

   function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   // funct3[2] picks the signed/unsigned compare flag over equality; funct3[0] inverts
   assign br_taken = (bus.funct3[2] ? bus.alu_res0 : bus.alu_zero) ^ bus.funct3[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = A_PC;
      alu_src_b  = B_RS2;
      alu_ctrl   = ALU_ADD;
      imm_sel    = IMM_I;
      case (state)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = B_FOUR;
            result_src = RES_ALU;
            if (bus.mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_nx = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_a = A_OLDPC;
            alu_src_b = B_IMM;
            imm_sel   = (bus.op == OP_BR) ? IMM_B : ((bus.op == OP_JAL) ? IMM_J : IMM_I);
            case (bus.op)
               OP_LOAD, OP_STORE: state_nx = S_MEMADR;
               OP_R:     state_nx = S_EXECR;
               OP_I:     state_nx = S_EXECI;
               OP_BR:    state_nx = (bus.funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
               OP_JAL:   state_nx = S_JAL;
               OP_JALR:  state_nx = S_JALR;
               OP_LUI:   state_nx = S_LUI;
               OP_AUIPC: state_nx = S_AUIPC;
               OP_FENCE: state_nx = S_FETCH;
               default:  state_nx = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = A_RS1;
            alu_src_b = B_IMM;
            imm_sel   = (bus.op == OP_STORE) ? IMM_S : IMM_I;
            state_nx  = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (bus.mem_ready) state_nx = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = RES_RDATA;
            reg_write  = 1'b1;
            state_nx   = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            adr_src = 1'b1;
            if (bus.mem_ready) state_nx = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a = A_RS1;
            alu_ctrl  = alu_dec(bus.funct3, bus.funct7b5);
            state_nx  = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a = A_RS1;
            alu_src_b = B_IMM;
            alu_ctrl  = alu_dec(bus.funct3, bus.funct7b5 && (bus.funct3 == 3'b101));
            state_nx  = S_ALUWB;
         end
         S_LUI: begin
            alu_src_a = A_ZERO;
            alu_src_b = B_IMM;
            imm_sel   = IMM_U;
            state_nx  = S_ALUWB;
         end
         S_AUIPC: begin
            alu_src_a = A_OLDPC;
            alu_src_b = B_IMM;
            imm_sel   = IMM_U;
            state_nx  = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            state_nx  = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = A_RS1;
            alu_ctrl  = !bus.funct3[2] ? ALU_SUB : (bus.funct3[1] ? ALU_SLTU : ALU_SLT);
            pc_write  = br_taken;
            pc_src    = 1'b1;
            state_nx  = S_FETCH;
         end
         S_JAL, S_JALRLINK: begin
            alu_src_a  = A_OLDPC;
            alu_src_b  = B_FOUR;
            result_src = RES_ALU;
            reg_write  = 1'b1;
            pc_write   = 1'b1;
            pc_src     = 1'b1;
            state_nx   = S_FETCH;
         end
         S_JALR: begin
            alu_src_a = A_RS1;
            alu_src_b = B_IMM;
            state_nx  = S_JALRLINK;
         end
         S_TRAP: begin
            illegal  = 1'b1;
            state_nx = S_TRAP;
         end
      endcase
   end

   // Reset forces every strobe low immediately, even though FETCH is the reset state
   assign bus.mem_req    = rst_n & mem_req;
   assign bus.mem_we     = rst_n & mem_we;
   assign bus.adr_src    = rst_n & adr_src;
   assign bus.ir_write   = rst_n & ir_write;
   assign bus.pc_write   = rst_n & pc_write;
   assign bus.pc_src     = rst_n & pc_src;
   assign bus.reg_write  = rst_n & reg_write;
   assign bus.illegal    = rst_n & illegal;
   assign bus.result_src = rst_n ? result_src : 2'b00;
   assign bus.alu_src_a  = rst_n ? alu_src_a  : 2'b00;
   assign bus.alu_src_b  = rst_n ? alu_src_b  : 2'b00;
   assign bus.alu_ctrl   = rst_n ? alu_ctrl   : 4'd0;
   assign bus.imm_sel    = rst_n ? imm_sel    : 3'b000;
endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios followed by random instruction
// streams, each cycle compared against per-instruction expected control sequences.
module tb_mc_ctrl;
   logic clk;
   logic rst_n;
   mc_ctrl_if bus ();

   mc_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       mem_req, mem_we, adr_src, ir_write, pc_write, pc_src, reg_write;
      logic [1:0] result_src, a, b;
      logic [3:0] alu;
      logic [2:0] imm;
      logic       illegal;
   } outs_t;

   int errors = 0;
   int checks = 0;

   function automatic outs_t observe();
      outs_t o;
      o = '{bus.mem_req, bus.mem_we, bus.adr_src, bus.ir_write, bus.pc_write, bus.pc_src,
            bus.reg_write, bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl,
            bus.imm_sel, bus.illegal};
      return o;
   endfunction

   task automatic check(input string tag, input outs_t exp);
      outs_t o;
      o = observe();
      checks++;
      assert (o === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h (op=%b f3=%b)", tag, o, exp, bus.op, bus.funct3);
      end
   endtask

   // drive ready for this cycle, check mid-cycle, advance to next negedge
   task automatic cyc(input string tag, input outs_t exp, input logic rdy);
      bus.mem_ready = rdy;
      #1;
      check(tag, exp);
      @(negedge clk);
   endtask

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   // ALU operation names by funct3 for register ops; alt selects sub/sra
   function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic alt);
      logic [3:0] tab [8];
      logic [3:0] v;
      tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
      v = tab[f3];
      if (alt && (f3 == 3'd0 || f3 == 3'd5)) v = v + 4'd1;
      return v;
   endfunction

   function automatic logic ref_taken(input logic [2:0] f3, input logic z, input logic r0);
      case (f3)
         3'd0:       return z;
         3'd1:       return !z;
         3'd4, 3'd6: return r0;
         default:    return !r0;
      endcase
   endfunction

   task automatic do_fetch(input int waits);
      outs_t e;
      e = '0; e.mem_req = 1; e.b = 2'd2; e.result_src = 2'd2;
      repeat (waits) cyc("fetch_wait", e, 1'b0);
      e.ir_write = 1; e.pc_write = 1;
      cyc("fetch", e, 1'b1);
   endtask

   task automatic mem_phase(input string tag, input logic we, input int waits);
      outs_t e;
      e = '0; e.mem_req = 1; e.mem_we = we; e.adr_src = 1;
      repeat (waits) cyc({tag, "_wait"}, e, 1'b0);
      cyc(tag, e, 1'b1);
   endtask

   task automatic trap_and_reset();
      outs_t e;
      e = '0; e.illegal = 1;
      cyc("trap", e, rnd());
      cyc("trap_hold", e, 1'b1);
      rst_n = 1'b0;
      #1;
      check("trap_reset", '0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Executes one instruction from FETCH back to FETCH, checking every cycle
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic z, input logic r0, input int fw, input int mw);
      outs_t e;
      bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.alu_zero = z; bus.alu_res0 = r0;
      do_fetch(fw);
      e = '0; e.a = 2'd1; e.b = 2'd1;
      e.imm = (op == 7'b1100011) ? 3'b010 : (op == 7'b1101111) ? 3'b011 : 3'b000;
      cyc("decode", e, rnd());
      case (op)
         7'b0000011: begin
            e = '0; e.a = 2'd2; e.b = 2'd1;
            cyc("memadr_ld", e, rnd());
            mem_phase("memread", 1'b0, mw);
            e = '0; e.result_src = 2'd1; e.reg_write = 1;
            cyc("memwb", e, rnd());
         end
         7'b0100011: begin
            e = '0; e.a = 2'd2; e.b = 2'd1; e.imm = 3'b001;
            cyc("memadr_st", e, rnd());
            mem_phase("memwrite", 1'b1, mw);
         end
         7'b0110011, 7'b0010011: begin
            e = '0; e.a = 2'd2;
            if (op == 7'b0110011) e.alu = ref_alu(f3, f7);
            else begin e.b = 2'd1; e.alu = ref_alu(f3, f7 && f3 == 3'd5); end
            cyc("exec", e, rnd());
            e = '0; e.reg_write = 1;
            cyc("aluwb", e, rnd());
         end
         7'b0110111, 7'b0010111: begin
            e = '0; e.a = (op == 7'b0110111) ? 2'd3 : 2'd1; e.b = 2'd1; e.imm = 3'b100;
            cyc("upper", e, rnd());
            e = '0; e.reg_write = 1;
            cyc("aluwb", e, rnd());
         end
         7'b1100011: begin
            if (f3 == 3'd2 || f3 == 3'd3) trap_and_reset();
            else begin
               e = '0; e.a = 2'd2; e.pc_src = 1;
               e.alu = (f3 < 3'd4) ? 4'd1 : (f3 < 3'd6) ? 4'd3 : 4'd4;
               e.pc_write = ref_taken(f3, z, r0);
               cyc("branch", e, rnd());
            end
         end
         7'b1101111, 7'b1100111: begin
            if (op == 7'b1100111) begin
               e = '0; e.a = 2'd2; e.b = 2'd1;
               cyc("jalr", e, rnd());
            end
            e = '0; e.a = 2'd1; e.b = 2'd2; e.result_src = 2'd2;
            e.reg_write = 1; e.pc_write = 1; e.pc_src = 1;
            cyc("link", e, rnd());
         end
         7'b0001111: ;
         default: trap_and_reset();
      endcase
   endtask

   initial begin
      logic [6:0] ops [11];
      logic [6:0] op;
      outs_t e;
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111,
              7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111, 7'b1110011};
      rst_n = 1'b0;
      bus.op = '0; bus.funct3 = '0; bus.funct7b5 = 0;
      bus.alu_zero = 0; bus.alu_res0 = 0; bus.mem_ready = 1;
      @(negedge clk);
      check("reset_idle", '0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed: sub, load with 3 wait cycles, bne both ways, jalr, ecall trap
      run_instr(7'b0110011, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0);
      run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 0, 3);
      run_instr(7'b1100011, 3'd1, 1'b0, 1'b0, 1'b0, 0, 0);
      run_instr(7'b1100011, 3'd1, 1'b0, 1'b1, 1'b0, 0, 0);
      run_instr(7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      run_instr(7'b1110011, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      run_instr(7'b0001111, 3'd0, 1'b0, 1'b0, 1'b0, 1, 0);

      // Reset during a stalled store abandons it; fetch restarts afterwards
      bus.op = 7'b0100011; bus.funct3 = 3'd2;
      do_fetch(0);
      e = '0; e.a = 2'd1; e.b = 2'd1;
      cyc("decode_st", e, 1'b1);
      e = '0; e.a = 2'd2; e.b = 2'd1; e.imm = 3'b001;
      cyc("memadr_st", e, 1'b1);
      e = '0; e.mem_req = 1; e.mem_we = 1; e.adr_src = 1;
      cyc("memwrite_wait", e, 1'b0);
      rst_n = 1'b0;
      #1;
      check("rst_memwrite", '0);
      @(negedge clk);
      rst_n = 1'b1;
      run_instr(7'b0010011, 3'd5, 1'b1, 1'b0, 1'b0, 0, 0);

      for (int n = 0; n < 300; n++) begin
         int k;
         k = int'($urandom_range(0, 11));
         if (k == 11) op = 7'($urandom);
         else op = ops[k];
         run_instr(op, 3'($urandom), rnd(), rnd(), rnd(),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle main controller for the RV32I core. Moore-style FSM that sequences the shared ALU, instruction/data memory port, register file and immediate extender across fetch, decode, execute, memory and writeback steps. Sits between the instruction register and the datapath muxes. Drives the extender's `imm_sel` with the same encoding: 000 I, 001 S, 010 B, 011 J, 1xx U.

## Interface

No parameters.

- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous active-low reset
- `op`  in  7  instruction register [6:0]
- `funct3`  in  3  instruction register [14:12]
- `funct7b5`  in  1  instruction register [30]
- `alu_zero`  in  1  ALU result == 0 (combinational)
- `alu_res0`  in  1  ALU result bit 0 (combinational)
- `mem_ready`  in  1  memory completes the current request this cycle
- `mem_req`  out  1  memory request; held until `mem_ready`
- `mem_we`  out  1  request is a write
- `adr_src`  out  1  memory address: 0 PC, 1 alu_out register
- `ir_write`  out  1  latch instruction register and old_pc
- `pc_write`  out  1  update PC
- `pc_src`  out  1  PC source: 0 result bus, 1 alu_out register
- `reg_write`  out  1  register file write of rd from result bus
- `result_src`  out  2  result bus: 00 alu_out register, 01 read data, 10 ALU result
- `alu_src_a`  out  2  00 PC, 01 old_pc, 10 rs1, 11 zero
- `alu_src_b`  out  2  00 rs2, 01 imm_ext, 10 constant 4
- `alu_ctrl`  out  4  0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and
- `imm_sel`  out  3  extender select
- `illegal`  out  1  controller trapped on an illegal instruction

## Operation

States, with asserted strobes and the default add/zero for unlisted fields:

- FETCH: `mem_req`, `adr_src`=0, ALU = PC+4 (a=00, b=10), `result_src`=10.
  - On `mem_ready`: `ir_write`, `pc_write` (`pc_src`=0), then DECODE.
  - Otherwise stay in FETCH.
- DECODE: ALU = old_pc+imm (a=01, b=01) into alu_out.
  - `imm_sel`: 010 for branch, 011 for jal, else 000.
  - Next state by `op`:
    - 0000011 / 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH (TRAP if `funct3` is 010 or 011)
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - 0010111 → AUIPC
    - 0001111 (fence) → FETCH
    - any other → TRAP
- MEMADR: ALU = rs1+imm. `imm_sel`=001 for store, else 000. Next: load → MEMREAD, store → MEMWRITE.
- MEMREAD: `mem_req`, `adr_src`=1; on `mem_ready` → MEMWB.
- MEMWB: `result_src`=01, `reg_write` → FETCH.
- MEMWRITE: `mem_req`, `mem_we`, `adr_src`=1; on `mem_ready` → FETCH.
- EXECR: a=10, b=00. `alu_ctrl` from `funct3`:
  - 000: add, or sub if `funct7b5`
  - 001 sll, 010 slt, 011 sltu, 100 xor
  - 101: srl, or sra if `funct7b5`
  - 110 or, 111 and
  - Next: ALUWB.
- EXECI: a=10, b=01, `imm_sel`=000. Same map, except `funct3`=000 is always add and `funct7b5` is honoured only for 101. Next: ALUWB.
- LUI: a=11, b=01, `imm_sel`=100, add → ALUWB.
- AUIPC: a=01, b=01, `imm_sel`=100, add → ALUWB.
- ALUWB: `result_src`=00, `reg_write` → FETCH.
- BRANCH: a=10, b=00.
  - `alu_ctrl`: sub for `funct3` 00x, slt for 10x, sltu for 11x.
  - Condition: beq `alu_zero`, bne !`alu_zero`, blt/bltu `alu_res0`, bge/bgeu !`alu_res0`.
  - `pc_write`=condition, `pc_src`=1. Next: FETCH.
- JAL: ALU = old_pc+4 (a=01, b=10), `result_src`=10, `reg_write`, `pc_write`, `pc_src`=1 → FETCH.
- JALR: ALU = rs1+imm (a=10, b=01, `imm_sel`=000) into alu_out → JALRLINK.
- JALRLINK: ALU = old_pc+4, `result_src`=10, `reg_write`, `pc_write`, `pc_src`=1 → FETCH.
- TRAP: `illegal`=1, all strobes 0. Exit only via reset.

## Timing

- Reset: asynchronous to FETCH. While `rst_n`=0, every strobe, `illegal` and `mem_req` are 0.
- First `mem_req` is in the first cycle after `rst_n` deasserts.
- All outputs are decoded from state only, except:
  - `ir_write`/`pc_write` in FETCH gated by `mem_ready`
  - `pc_write` in BRANCH gated by the condition
- `mem_req` and the address select stay stable until `mem_ready`. No new request is issued in the completing cycle.
- Cycles per instruction at zero wait (`mem_ready` tied 1):
  - load 5
  - store, R-type, I-type, lui, auipc, jalr 4
  - branch, jal 3
  - fence 2
- Each wait cycle adds 1.
- Reset asserted mid-instruction abandons it: no register or PC write is issued.

## Test plan

- `mem_ready`=1, `op`=0110011, `funct3`=000, `funct7b5`=1 → states FETCH, DECODE, EXECR, ALUWB; `alu_ctrl`=1 in EXECR; `reg_write` only in ALUWB.
- Load with `mem_ready` low for 3 cycles in MEMREAD → `mem_req`=1 and `adr_src`=1 held 4 cycles; MEMWB `result_src`=01; 8 cycles total.
- Branch `funct3`=001 with `alu_zero`=0 → `pc_write`=1, `pc_src`=1. Same with `alu_zero`=1 → `pc_write`=0. Back to FETCH after 3 cycles.
- jalr → JALR `imm_sel`=000, a=10; JALRLINK asserts `reg_write`, `pc_write` and `pc_src`=1 together.
- `op`=1110011 → TRAP, `illegal`=1, no `mem_req`. `rst_n` pulse → FETCH, `illegal`=0.
- `rst_n` asserted during MEMWRITE with `mem_ready`=0 → `mem_req`/`mem_we` drop the same cycle; after release, fetch restarts.
